// File: rtl/framebuffer_mem_controller.sv
// framebuffer_mem_controller
// Byte-wide read responder for the display controller backed by a downscaled RGB565
// framebuffer held in one single-port 16-bit word RAM. Three users share that port:
// display reads (highest priority), the clear engine, then producer pixel writes.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   mem_req, mem_addr byte read request (accepted every cycle)
//   mem_ready, mem_out read response, exactly two cycles after mem_req
//   wr_valid, wr_addr, wr_data, wr_ready   pixel write handshake (row-major index)
//   wr_oob            pulses the cycle after an accepted write whose index is >= DEPTH
//   clear_start       pulse that starts a fill with CLEAR_COLOR
//   clear_busy        high while the fill is running
module framebuffer_mem_controller #(
   parameter int unsigned DISPLAY_X       = 320,
   parameter int unsigned DISPLAY_Y       = 240,
   parameter int unsigned DOWNSCALE_SHIFT = 2,
   parameter logic [15:0] CLEAR_COLOR     = 16'h0000,
   parameter bit          CLEAR_ON_RESET  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   output logic        mem_ready,
   output logic [7:0]  mem_out,
   input  logic        wr_valid,
   input  logic [15:0] wr_addr,
   input  logic [15:0] wr_data,
   output logic        wr_ready,
   output logic        wr_oob,
   input  logic        clear_start,
   output logic        clear_busy
);

   localparam int unsigned FB_X  = DISPLAY_X >> DOWNSCALE_SHIFT;
   localparam int unsigned FB_Y  = DISPLAY_Y >> DOWNSCALE_SHIFT;
   localparam int unsigned DEPTH = FB_X * FB_Y;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0]   RD_LIMIT = 32'(2 * DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [0:0] {StIdle, StClear} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_idx_q, clr_idx_d;
   logic            clr_we;
   // Set on the first edge after reset release; gates writes and the auto-clear.
   logic            init_q;

   logic            rd_s1_q;
   logic [AW-1:0]   rd_idx_q;
   logic            rd_lo_q;
   logic            rd_oob_q;

   logic            mem_ready_q;
   // Forces mem_out to zero for out-of-range reads and out of reset, so the
   // unreset RAM output register never leaks onto the bus.
   logic            out_zero_q;
   logic            out_lo_q;
   logic [15:0]     rd_word_q;
   logic            wr_oob_q;

   logic            wr_fire;
   logic            wr_in_range;
   logic            wr_we;
   logic            ram_we;
   logic [AW-1:0]   ram_waddr;
   logic [15:0]     ram_wdata;

   logic [15:0]     ram [DEPTH];

   // Clear engine: pauses whenever a read owns the RAM port.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clr_we    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (clear_start || (CLEAR_ON_RESET && !init_q)) begin
               state_d   = StClear;
               clr_idx_d = '0;
            end
         end
         StClear: begin
            if (!rd_s1_q) begin
               clr_we = 1'b1;
               if (clr_idx_q == LAST_IDX) begin
                  state_d = StIdle;
               end else begin
                  clr_idx_d = clr_idx_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign wr_ready    = (state_q == StIdle) & ~rd_s1_q & init_q;
   assign wr_fire     = wr_valid & wr_ready;
   assign wr_in_range = 32'(wr_addr) < DEPTH;
   assign wr_we       = wr_fire & wr_in_range;

   // Reads, clear and writes are mutually exclusive by construction of wr_ready.
   assign ram_we    = clr_we | wr_we;
   assign ram_waddr = clr_we ? clr_idx_q : wr_addr[AW-1:0];
   assign ram_wdata = clr_we ? CLEAR_COLOR : wr_data;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_waddr] <= ram_wdata;
      end
      if (rd_s1_q && !rd_oob_q) begin
         rd_word_q <= ram[rd_idx_q];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         clr_idx_q   <= '0;
         init_q      <= 1'b0;
         rd_s1_q     <= 1'b0;
         rd_idx_q    <= '0;
         rd_lo_q     <= 1'b0;
         rd_oob_q    <= 1'b0;
         mem_ready_q <= 1'b0;
         out_zero_q  <= 1'b1;
         out_lo_q    <= 1'b0;
         wr_oob_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_idx_q   <= clr_idx_d;
         init_q      <= 1'b1;
         rd_s1_q     <= mem_req;
         if (mem_req) begin
            rd_idx_q <= mem_addr[AW:1];
            rd_lo_q  <= mem_addr[0];
            rd_oob_q <= mem_addr >= RD_LIMIT;
         end
         mem_ready_q <= rd_s1_q;
         if (rd_s1_q) begin
            out_zero_q <= rd_oob_q;
            out_lo_q   <= rd_lo_q;
         end
         wr_oob_q    <= wr_fire & ~wr_in_range;
      end
   end

   // Even byte address is the MSB of the pixel word (panel order is MSB first).
   assign mem_out    = out_zero_q ? 8'h00 : (out_lo_q ? rd_word_q[7:0] : rd_word_q[15:8]);
   assign mem_ready  = mem_ready_q;
   assign wr_oob     = wr_oob_q;
   assign clear_busy = (state_q == StClear);

endmodule

// File: doc/framebuffer_mem_controller.md
# framebuffer_mem_controller

Responder for the display controller's byte-wide memory request interface (`mem_req`/`mem_addr` in, `mem_ready`/`mem_out` out). It replaces the combinational color-bar mock with a real downscaled RGB565 framebuffer. A pixel-write port from a producer fills the framebuffer, and an internal clear engine fills it with a constant color. All three share one single-port word RAM, with fixed-priority arbitration.

## Interface
Parameters:
- `DISPLAY_X`, 320: panel width in pixels.
- `DISPLAY_Y`, 240: panel height in pixels.
- `DOWNSCALE_SHIFT`, 2: framebuffer dimensions are `DISPLAY_X>>DOWNSCALE_SHIFT` by `DISPLAY_Y>>DOWNSCALE_SHIFT`.
- `CLEAR_COLOR`, 16'h0000: RGB565 value written by the clear engine.
- `CLEAR_ON_RESET`, 1: when 1, the clear engine starts automatically after reset release.

Ports:
- `clk` in 1: system clock (12 MHz).
- `reset` in 1: asynchronous, active-low reset.
- `mem_req` in 1: single-cycle read request from the display controller.
- `mem_addr` in 32: byte address of the request.
- `mem_ready` out 1: single-cycle pulse; `mem_out` is valid in the same cycle.
- `mem_out` out 8: read data byte.
- `wr_valid` in 1: pixel write request.
- `wr_addr` in 16: pixel index, row-major (`y*FB_X + x`).
- `wr_data` in 16: RGB565 pixel value.
- `wr_ready` out 1: write is accepted in any cycle where `wr_valid & wr_ready`.
- `wr_oob` out 1: single-cycle pulse when an accepted write had `wr_addr >= DEPTH`.
- `clear_start` in 1: pulse that starts the clear engine.
- `clear_busy` out 1: high while the clear engine is running.

## Operation
- Derived values: `FB_X = DISPLAY_X>>DOWNSCALE_SHIFT`, `FB_Y = DISPLAY_Y>>DOWNSCALE_SHIFT`, `DEPTH = FB_X*FB_Y`. With defaults, DEPTH is 4800 words (9600 bytes). The RAM is 16 bits × DEPTH.
- Byte mapping: pixel index `= mem_addr>>1`.
  - `mem_addr[0]=0` returns `word[15:8]`.
  - `mem_addr[0]=1` returns `word[7:0]`.
  - This matches the panel's MSB-first RGB565 order.
- Reads with `mem_addr >= 2*DEPTH` still complete with the same latency and return `8'h00`.
- Read pipeline:
  - Stage `rd_s1` registers the request and address.
  - The RAM is read in the `rd_s1` cycle.
  - Stage 2 drives `mem_ready` and `mem_out`.
  - Reads are never stalled or dropped. `mem_req` is accepted in any cycle, including back-to-back cycles.
- RAM port priority, highest first: read (`rd_s1`), then clear, then write.
- `wr_ready = (state==IDLE) & ~rd_s1 & reset released`.
- An accepted write commits at the accepting edge. If `wr_addr >= DEPTH`, the RAM is not written and `wr_oob` pulses on the next cycle.
- State machine:
  - `IDLE`: a `clear_start` pulse, or reset release with `CLEAR_ON_RESET=1`, moves to `CLEAR` with `clr_idx=0`.
  - `CLEAR`: in each cycle with `~rd_s1`, writes `CLEAR_COLOR` at `clr_idx` and increments it. After writing `clr_idx == DEPTH-1`, returns to `IDLE`. Cycles with `rd_s1=1` pause the clear; `clr_idx` holds.
- `clear_start` while in `CLEAR` is ignored. The clear does not restart.
- Reads during `CLEAR` return the current RAM content, so a partially cleared frame is legal.
- `mem_out` holds its last value when `mem_ready` is low.

## Timing
- Reset values: `mem_ready=0`, `mem_out=8'h00`, `wr_ready=0`, `wr_oob=0`, `clear_busy=0`, state `IDLE`, `rd_s1=0`.
- RAM contents are not altered by reset.
- Reset asserted mid-read: the in-flight `mem_ready` is not produced.
- Reset asserted mid-clear: `clear_busy` drops immediately and `clr_idx` is discarded.
- Read latency: `mem_req` high in cycle N gives `mem_ready=1` and valid `mem_out` in cycle N+2, exactly one pulse per request.
- Throughput: one read per cycle.
- A write accepted at edge N is visible to a read whose `rd_s1` stage is cycle N+1 or later.
- `clear_busy` rises the cycle after the triggering edge and falls the cycle after the final word is written.
- Unstalled clear duration: DEPTH cycles.
- Release with `CLEAR_ON_RESET=1`: `clear_busy=1` from the first cycle after release, and `wr_ready` stays low until the clear completes.

## Test plan
- Reset release with `CLEAR_ON_RESET=1`, `CLEAR_COLOR=16'hF800`, no traffic -> `clear_busy` high for exactly 4800 cycles. A read of address 9599 then returns `8'h00` at N+2; address 9598 returns `8'hF8`.
- Write pixel 17 = 16'h07E0, then read bytes 34 and 35 -> `mem_out` `8'h07` then `8'hE0`, each exactly 2 cycles after its `mem_req`.
- Issue `mem_req` on 10 consecutive cycles over addresses 0..9 while `wr_valid` is held high -> 10 `mem_ready` pulses on consecutive cycles. `wr_ready` stays low in each `rd_s1` cycle, and the write lands afterwards.
- `wr_addr=4800` with `wr_valid` -> accepted, `wr_oob` pulses once, RAM is unchanged. Read of `mem_addr=9600` -> `8'h00` with normal latency.
- `clear_start` during a running clear, interleaved with reads -> no restart. Total `clear_busy` duration = 4800 + number of read cycles that overlapped the clear.
- Assert reset mid-clear at index 2000 with `CLEAR_ON_RESET=0` -> all outputs return to reset values asynchronously. Words 0..1999 hold `CLEAR_COLOR`; word 2000 and above keep their earlier values.
